apb_sram_ctrl: RTL

APB4 slave fronting an internal single-port, byte-lane-writable SRAM. Generalises the fixed 32-bit/1024-word APB SRAM interface with the following additions:
- parametrised data width and depth
- byte strobes (PSTRB)
- programmable wait states
- PSLVERR on out-of-range or misaligned access
- a saturating error counter

Sits on the peripheral APB bus as a scratch/buffer memory.

---
 rtl/apb_sram_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/apb_sram_ctrl.sv
// APB4 slave in front of a single-port, byte-lane-writable SRAM with programmable
// wait states, PSLVERR on misaligned/out-of-range accesses and a saturating error counter.
module apb_sram_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PADDR_W     = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [PADDR_W-1:0]    paddr,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr,
  output logic [ERRCNT_W-1:0]   err_cnt,
  output logic                  busy
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(NBYTES);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned IDX_W  = PADDR_W - LSB;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEM, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]         widx_q, widx_d;
  logic                  wr_q, wr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NBYTES-1:0]     strb_q, strb_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                  busy_q, busy_d;
  logic                  mem_we;

  logic [IDX_W-1:0]      idx_c;
  logic                  misalign_c;
  logic                  oor_c;

  logic [DATA_W-1:0]     mem [DEPTH];

  // Address decode of the setup-phase address
  always_comb begin
    idx_c      = IDX_W'(paddr >> LSB);
    misalign_c = (paddr & PADDR_W'(NBYTES - 1)) != '0;
    oor_c      = 32'(idx_c) >= DEPTH;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    widx_d    = widx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          widx_d  = AW'(idx_c);
          wr_d    = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = misalign_c || oor_c;
          wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_MEM;
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          state_d = S_MEM;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_MEM: begin
        // A write reaching MEM is committed even if the master has already let go
        mem_we = wr_q && !err_q;
        if (!psel) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          if (!wr_q && !err_q) prdata_d = mem[widx_q];
          if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      widx_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      widx_q    <= widx_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // SRAM array is not reset; byte lanes written individually
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (strb_q[i]) mem[widx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;

endmodule
